envelope_shaper: RTL
====================

// Module: envelope_shaper
// PURPOSE
//  ADSR amplitude envelope stage; sits directly downstream of the square wave generator.
//  Takes raw square_out samples plus a note gate and scales each sample by an envelope level.
//  The level is driven by an attack/decay/sustain/release state machine.
//  Output feeds the audio DAC/PWM stage. Turns fixed-amplitude tones into shaped notes.
// PARAMETERS
//  resolution_bits  8    width of sample_in/sample_out (matches square wave generator)
//  env_bits         8    width of envelope level and step/level controls
//  tick_div         256  clk cycles per envelope update tick (>=2)
// PORTS
//  clk            in   1                system clock
//  reset          in   1                asynchronous, active-low reset
//  sample_in      in   resolution_bits  unsigned sample from square wave generator
//  gate           in   1                note on (1) / note off (0), synchronous to clk
//  attack_step    in   env_bits         level increment per tick in ATTACK
//  decay_step     in   env_bits         level decrement per tick in DECAY
//  sustain_level  in   env_bits         DECAY target / SUSTAIN hold level
//  release_step   in   env_bits         level decrement per tick in RELEASE
//  sample_out     out  resolution_bits  shaped sample
//  env_level      out  env_bits         current envelope level
//  env_state      out  3                current state encoding
//  busy           out  1                1 whenever env_state != IDLE
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; env_level, sample_out, busy, gate_d, tick counter all 0.
//  Reset mid-note aborts immediately; no release tail.
//  Tick: free-running counter 0..tick_div-1; env_tick pulses 1 clk when count==tick_div-1, then wraps to 0.
//  Level changes only on env_tick. State changes on gate edges (any clk) or on env_tick.
//  Gate edges come from the registered gate_d.
//  rise = gate & ~gate_d; fall = ~gate & gate_d.
//  States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
//  IDLE: level 0; rise -> ATTACK.
//  ATTACK: level += attack_step, saturating at MAX=2^env_bits-1; on reaching MAX -> DECAY.
//  DECAY: level -= decay_step, clamped at sustain_level; on reaching it -> SUSTAIN.
//  SUSTAIN: level = sustain_level, re-sampled every tick.
//  RELEASE: level -= release_step, clamped at 0; on reaching 0 -> IDLE.
//  fall in ATTACK/DECAY/SUSTAIN -> RELEASE. Level is kept, so release starts from the current level.
//  rise in RELEASE (retrigger) -> ATTACK from the current level. No reset to 0.
//  Simultaneous gate edge and tick-driven transition in the same clk: the gate edge wins.
//  Example: fall on the same clk ATTACK hits MAX -> RELEASE, not DECAY.
//  Zero step in ATTACK/DECAY/RELEASE: level holds and state holds until a gate edge.
//  sustain_level above the current level on DECAY entry: DECAY -> SUSTAIN on the next tick.
//  That tick sets level = sustain_level.
//  Arithmetic: add/sub done in env_bits+1 bits, then clamped. No wrap-around ever.
//  sample_out = (sample_in * env_level) >> env_bits.
//  Product is resolution_bits+env_bits wide and registered.
//  Latency: 1 clk from sample_in/env_level to sample_out.
//  busy and env_state are registered and reflect the current state.
// STRUCTURE
//  Shared header envelope_defs.vh: state encodings (ENV_IDLE..ENV_RELEASE), state width 3.
//  Sub-module tick_divider: parameter tick_div.
//  tick_divider ports: clk, reset, tick out. Reused by other timing stages.
//  Top: gate edge register, ADSR FSM + level register, registered multiply.
// TESTING
//  Reset: all outputs 0 and state IDLE, checked both mid-ATTACK and mid-RELEASE.
//  Full ADSR, params tick_div=4, steps 64/32/—/16, sustain 128, sample_in=8'hFF, gate high 40 clk:
//    -> level ramps 64,128,192,255 (saturates at 255, not 256).
//    -> DECAY ramps 223,191,159,128, then SUSTAIN.
//    -> after gate low: RELEASE reaches 0 in 8 ticks, then IDLE, busy=0.
//  Early release: drop gate while level=128 in ATTACK -> RELEASE from 128, with no DECAY visited.
//  Retrigger: raise gate at level=48 in RELEASE -> ATTACK continues 112,176,...
//  Same-clk collision: fall coincides with ATTACK reaching 255 -> next state RELEASE.
//  Multiply: sample_in=8'hFF, env_level=128 -> sample_out=127 one clk later.
//  Multiply: sample_in=0 -> sample_out=0 regardless of level.

Source files
------------

// File: rtl/envelope_shaper_pkg.sv
// rtl/envelope_shaper_pkg.sv - shared ADSR state encodings for the envelope shaper
package envelope_shaper_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-clk tick every tick_div clks
module tick_divider #(
  parameter int tick_div = 256
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (tick_div > 2) ? $clog2(tick_div) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(tick_div - 1));

  // wrap to zero on the terminal count, otherwise count up
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/envelope_shaper.sv
// rtl/envelope_shaper.sv - ADSR envelope generator scaling square wave samples
module envelope_shaper #(
  parameter int resolution_bits = 8,
  parameter int env_bits        = 8,
  parameter int tick_div        = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [resolution_bits-1:0] sample_in,
  input  logic                       gate,
  input  logic [env_bits-1:0]        attack_step,
  input  logic [env_bits-1:0]        decay_step,
  input  logic [env_bits-1:0]        sustain_level,
  input  logic [env_bits-1:0]        release_step,
  output logic [resolution_bits-1:0] sample_out,
  output logic [env_bits-1:0]        env_level,
  output logic [2:0]                 env_state,
  output logic                       busy
);

  import envelope_shaper_pkg::*;

  localparam int PW = resolution_bits + env_bits;
  localparam logic [env_bits:0] MAX_W = {1'b0, {env_bits{1'b1}}};

  logic                       env_tick;
  logic                       gate_q;
  logic                       gate_d;
  logic                       rise;
  logic                       fall;
  env_state_e                 state_q;
  env_state_e                 state_d;
  logic [env_bits-1:0]        level_q;
  logic [env_bits-1:0]        level_d;
  logic                       busy_q;
  logic                       busy_d;
  logic [resolution_bits-1:0] sample_out_q;
  logic [resolution_bits-1:0] sample_out_d;
  logic [env_bits:0]          sum_w;
  logic [env_bits:0]          dec_w;
  logic [env_bits:0]          rel_w;
  logic [PW-1:0]              prod_w;

  tick_divider #(
    .tick_div(tick_div)
  ) u_tick_divider (
    .clk  (clk),
    .reset(reset),
    .tick (env_tick)
  );

  assign gate_d = gate;
  assign rise   = gate & ~gate_q;
  assign fall   = ~gate & gate_q;

  // next state and level; gate edges take priority over tick-driven moves
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    sum_w   = {1'b0, level_q} + {1'b0, attack_step};
    dec_w   = {1'b0, level_q} - {1'b0, decay_step};
    rel_w   = {1'b0, level_q} - {1'b0, release_step};
    case (state_q)
      ENV_IDLE: begin
        level_d = '0;
        if (rise) begin
          state_d = ENV_ATTACK;
        end
      end
      ENV_ATTACK: begin
        if (fall) begin
          state_d = ENV_RELEASE;
        end else if (env_tick && (attack_step != '0)) begin
          if (sum_w >= MAX_W) begin
            level_d = '1;
            state_d = ENV_DECAY;
          end else begin
            level_d = sum_w[env_bits-1:0];
          end
        end
      end
      ENV_DECAY: begin
        if (fall) begin
          state_d = ENV_RELEASE;
        end else if (env_tick) begin
          if (level_q <= sustain_level) begin
            level_d = sustain_level;
            state_d = ENV_SUSTAIN;
          end else if (decay_step != '0) begin
            if (dec_w[env_bits] || (dec_w[env_bits-1:0] <= sustain_level)) begin
              level_d = sustain_level;
              state_d = ENV_SUSTAIN;
            end else begin
              level_d = dec_w[env_bits-1:0];
            end
          end
        end
      end
      ENV_SUSTAIN: begin
        if (fall) begin
          state_d = ENV_RELEASE;
        end else if (env_tick) begin
          level_d = sustain_level;
        end
      end
      ENV_RELEASE: begin
        if (rise) begin
          state_d = ENV_ATTACK;
        end else if (env_tick && (release_step != '0)) begin
          if (rel_w[env_bits] || (rel_w == '0)) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = rel_w[env_bits-1:0];
          end
        end
      end
      default: begin
        state_d = ENV_IDLE;
        level_d = '0;
      end
    endcase
    busy_d = (state_d != ENV_IDLE);
  end

  // scale the incoming sample by the current level, keeping the top bits
  always_comb begin
    prod_w       = {{env_bits{1'b0}}, sample_in} * {{resolution_bits{1'b0}}, level_q};
    sample_out_d = resolution_bits'(prod_w >> env_bits);
  end

  // state, level, gate history and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ENV_IDLE;
      level_q      <= '0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
      sample_out_q <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      gate_q       <= gate_d;
      busy_q       <= busy_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign env_level  = level_q;
  assign env_state  = state_q;
  assign busy       = busy_q;

endmodule
